// File: rtl/jedro_1_pkg.sv
// Shared definitions for the jedro_1 RV32I integer core slice.
// Holds opcode/funct constants, the ALU operation enum, the default boot
// address and a helper mapping funct3 (+ alternate bit) to an ALU operation.
package jedro_1_pkg;

  localparam logic [31:0] BootAddrDefault = 32'h0000_0000;

  // Major opcodes (full 7 bits, so opcode[1:0] != 2'b11 never matches)
  localparam logic [6:0] OpcLui   = 7'b0110111;
  localparam logic [6:0] OpcAuipc = 7'b0010111;
  localparam logic [6:0] OpcOpImm = 7'b0010011;
  localparam logic [6:0] OpcOp    = 7'b0110011;

  localparam logic [2:0] F3AddSub = 3'b000;
  localparam logic [2:0] F3Sll    = 3'b001;
  localparam logic [2:0] F3Slt    = 3'b010;
  localparam logic [2:0] F3Sltu   = 3'b011;
  localparam logic [2:0] F3Xor    = 3'b100;
  localparam logic [2:0] F3Srl    = 3'b101;
  localparam logic [2:0] F3Or     = 3'b110;
  localparam logic [2:0] F3And    = 3'b111;

  localparam logic [6:0] F7Base = 7'b0000000;
  localparam logic [6:0] F7Alt  = 7'b0100000;

  typedef enum logic [3:0] {
    AluAdd,
    AluSub,
    AluSll,
    AluSlt,
    AluSltu,
    AluXor,
    AluSrl,
    AluSra,
    AluOr,
    AluAnd
  } alu_op_e;

  // alt selects SUB over ADD and SRA over SRL.
  function automatic alu_op_e alu_op_from(input logic [2:0] funct3, input logic alt);
    alu_op_e op;
    case (funct3)
      F3AddSub: op = alt ? AluSub : AluAdd;
      F3Sll:    op = AluSll;
      F3Slt:    op = AluSlt;
      F3Sltu:   op = AluSltu;
      F3Xor:    op = AluXor;
      F3Srl:    op = alt ? AluSra : AluSrl;
      F3Or:     op = AluOr;
      default:  op = AluAnd;
    endcase
    return op;
  endfunction

endpackage

// File: rtl/jedro_1_decoder.sv
// Instruction decoder for the supported RV32I subset.
// Ports: clk_i/rst_ni, instr_i (word from instruction memory), valid_i
// (instr_i holds a real fetched word); outputs the decoded fields
// (alu_op_o, rd_o, rs1_o, rs2_o, imm_o, operand selects), the combinational
// illegal_o and the sticky registered illegal_instr_ro.
module jedro_1_decoder
  import jedro_1_pkg::*;
(
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic [31:0] instr_i,
  input  logic        valid_i,
  output logic        illegal_o,
  output logic        illegal_instr_ro,
  output alu_op_e     alu_op_o,
  output logic [4:0]  rd_o,
  output logic [4:0]  rs1_o,
  output logic [4:0]  rs2_o,
  output logic [31:0] imm_o,
  output logic        use_imm_o,
  output logic        zero_a_o,
  output logic        pc_a_o
);

  logic [6:0] opcode;
  logic [2:0] funct3;
  logic [6:0] funct7;
  logic       illegal_q;

  assign opcode = instr_i[6:0];
  assign funct3 = instr_i[14:12];
  assign funct7 = instr_i[31:25];
  assign rd_o   = instr_i[11:7];
  assign rs1_o  = instr_i[19:15];
  assign rs2_o  = instr_i[24:20];

  always_comb begin
    illegal_o = 1'b1;
    alu_op_o  = AluAdd;
    imm_o     = {{20{instr_i[31]}}, instr_i[31:20]};
    use_imm_o = 1'b0;
    zero_a_o  = 1'b0;
    pc_a_o    = 1'b0;
    case (opcode)
      OpcLui: begin
        illegal_o = 1'b0;
        imm_o     = {instr_i[31:12], 12'd0};
        use_imm_o = 1'b1;
        zero_a_o  = 1'b1;
      end
      OpcAuipc: begin
        illegal_o = 1'b0;
        imm_o     = {instr_i[31:12], 12'd0};
        use_imm_o = 1'b1;
        pc_a_o    = 1'b1;
      end
      OpcOpImm: begin
        use_imm_o = 1'b1;
        // Only the right shift reads funct7 as an operation modifier.
        alu_op_o  = alu_op_from(funct3, (funct3 == F3Srl) && (funct7 == F7Alt));
        case (funct3)
          F3Sll:   illegal_o = (funct7 != F7Base);
          F3Srl:   illegal_o = !((funct7 == F7Base) || (funct7 == F7Alt));
          default: illegal_o = 1'b0;
        endcase
      end
      OpcOp: begin
        alu_op_o  = alu_op_from(funct3, funct7 == F7Alt);
        illegal_o = !((funct7 == F7Base) ||
                      ((funct7 == F7Alt) && ((funct3 == F3AddSub) || (funct3 == F3Srl))));
      end
      default: illegal_o = 1'b1;
    endcase
  end

  // Sticky until reset.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      illegal_q <= 1'b0;
    end else if (valid_i && illegal_o) begin
      illegal_q <= 1'b1;
    end
  end

  assign illegal_instr_ro = illegal_q;

endmodule

// File: rtl/jedro_1_regfile.sv
// 32 x 32-bit integer register file.
// Ports: clk_i/rst_ni (async active-low reset clears all entries),
// one write port (we_i, waddr_i, wdata_i) and two asynchronous read ports
// (raddr_a_i/rdata_a_o, raddr_b_i/rdata_b_o). x0 ignores writes and reads 0.
module jedro_1_regfile (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        we_i,
  input  logic [4:0]  waddr_i,
  input  logic [31:0] wdata_i,
  input  logic [4:0]  raddr_a_i,
  output logic [31:0] rdata_a_o,
  input  logic [4:0]  raddr_b_i,
  output logic [31:0] rdata_b_o
);

  logic [31:0] regfile [0:31];

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < 32; i++) begin
        regfile[i] <= '0;
      end
    end else if (we_i && (waddr_i != 5'd0)) begin
      regfile[waddr_i] <= wdata_i;
    end
  end

  assign rdata_a_o = (raddr_a_i == 5'd0) ? 32'd0 : regfile[raddr_a_i];
  assign rdata_b_o = (raddr_b_i == 5'd0) ? 32'd0 : regfile[raddr_b_i];

endmodule

// File: rtl/jedro_1_top.sv
// jedro_1 core: 3-stage in-order RV32I-subset pipeline (fetch, decode,
// execute/writeback) with no branches, loads or stores.
// Ports: clk_i, rstn_i (async active-low); iram_addr/iram_rdata to a
// synchronous instruction ROM (one cycle latency); dram_* data port held idle.
// Parameter BOOT_ADDR: first fetch address after reset.
module jedro_1_top
  import jedro_1_pkg::*;
#(
  parameter logic [31:0] BOOT_ADDR = BootAddrDefault
) (
  input  logic        clk_i,
  input  logic        rstn_i,
  output logic [31:0] iram_addr,
  input  logic [31:0] iram_rdata,
  output logic [3:0]  dram_we,
  output logic        dram_stb,
  output logic [31:0] dram_addr,
  output logic [31:0] dram_wdata,
  input  logic [31:0] dram_rdata,
  input  logic        dram_ack,
  input  logic        dram_err
);

  // Fetch stage: pc_q is on the ROM address; if_pc_q is the address of the
  // word currently on iram_rdata.
  logic [31:0] pc_q, if_pc_q;
  logic        if_valid_q;
  logic        halted;

  // Decoder outputs
  logic        dec_illegal;
  alu_op_e     dec_alu_op;
  logic [4:0]  dec_rd, dec_rs1, dec_rs2;
  logic [31:0] dec_imm;
  logic        dec_use_imm, dec_zero_a, dec_pc_a;
  logic        id_valid;

  // Register file / forwarding
  logic [31:0] rf_a, rf_b, rs1_val, rs2_val;
  logic        wb_we;

  // Execute stage
  logic        ex_valid_q;
  alu_op_e     ex_op_q;
  logic [4:0]  ex_rd_q;
  logic [31:0] ex_a_q, ex_b_q;
  logic [31:0] alu_res;
  logic [4:0]  shamt;

  assign iram_addr = pc_q;

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      pc_q       <= BOOT_ADDR;
      if_pc_q    <= BOOT_ADDR;
      if_valid_q <= 1'b0;
    end else if (!halted) begin
      pc_q       <= pc_q + 32'd4;
      if_pc_q    <= pc_q;
      if_valid_q <= 1'b1;
    end
  end

  jedro_1_decoder decoder_inst (
    .clk_i            (clk_i),
    .rst_ni           (rstn_i),
    .instr_i          (iram_rdata),
    .valid_i          (if_valid_q),
    .illegal_o        (dec_illegal),
    .illegal_instr_ro (halted),
    .alu_op_o         (dec_alu_op),
    .rd_o             (dec_rd),
    .rs1_o            (dec_rs1),
    .rs2_o            (dec_rs2),
    .imm_o            (dec_imm),
    .use_imm_o        (dec_use_imm),
    .zero_a_o         (dec_zero_a),
    .pc_a_o           (dec_pc_a)
  );

  // Nothing at or after the illegal word enters execute.
  assign id_valid = if_valid_q && !dec_illegal && !halted;

  // Older instructions still in execute retire in the cycle the halt flag sets;
  // the flag is registered, so it only masks writes from the next cycle on.
  assign wb_we = ex_valid_q && !halted && (ex_rd_q != 5'd0);

  jedro_1_regfile regfile_inst (
    .clk_i     (clk_i),
    .rst_ni    (rstn_i),
    .we_i      (wb_we),
    .waddr_i   (ex_rd_q),
    .wdata_i   (alu_res),
    .raddr_a_i (dec_rs1),
    .rdata_a_o (rf_a),
    .raddr_b_i (dec_rs2),
    .rdata_b_o (rf_b)
  );

  // Writeback-to-decode bypass: the regfile write lands on the same edge
  // that captures the operands, so the array read would be one value stale.
  assign rs1_val = (wb_we && (ex_rd_q == dec_rs1)) ? alu_res : rf_a;
  assign rs2_val = (wb_we && (ex_rd_q == dec_rs2)) ? alu_res : rf_b;

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      ex_valid_q <= 1'b0;
      ex_op_q    <= AluAdd;
      ex_rd_q    <= 5'd0;
      ex_a_q     <= '0;
      ex_b_q     <= '0;
    end else begin
      ex_valid_q <= id_valid;
      ex_op_q    <= dec_alu_op;
      ex_rd_q    <= dec_rd;
      ex_a_q     <= dec_zero_a ? 32'd0 : (dec_pc_a ? if_pc_q : rs1_val);
      ex_b_q     <= dec_use_imm ? dec_imm : rs2_val;
    end
  end

  assign shamt = ex_b_q[4:0];

  always_comb begin
    alu_res = '0;
    case (ex_op_q)
      AluAdd:  alu_res = ex_a_q + ex_b_q;
      AluSub:  alu_res = ex_a_q - ex_b_q;
      AluSll:  alu_res = ex_a_q << shamt;
      AluSlt:  alu_res = {31'd0, $signed(ex_a_q) < $signed(ex_b_q)};
      AluSltu: alu_res = {31'd0, ex_a_q < ex_b_q};
      AluXor:  alu_res = ex_a_q ^ ex_b_q;
      AluSrl:  alu_res = ex_a_q >> shamt;
      AluSra:  alu_res = $signed(ex_a_q) >>> shamt;
      AluOr:   alu_res = ex_a_q | ex_b_q;
      AluAnd:  alu_res = ex_a_q & ex_b_q;
      default: alu_res = '0;
    endcase
  end

  // Data port is not used by this subset.
  assign dram_we    = 4'd0;
  assign dram_stb   = 1'b0;
  assign dram_addr  = 32'd0;
  assign dram_wdata = 32'd0;

  logic unused_dram;
  assign unused_dram = ^{dram_rdata, dram_ack, dram_err};

endmodule

// File: tb/tb_jedro_1_top.sv
module tb_jedro_1_top;

  localparam logic [31:0] Boot = 32'h0000_0080;

  logic        clk;
  logic        rstn;
  logic [31:0] iram_addr, iram_rdata;
  logic [3:0]  dram_we;
  logic        dram_stb;
  logic [31:0] dram_addr, dram_wdata;

  int checks = 0;
  int errors = 0;

  logic [31:0] imem [0:63];
  logic [31:0] mregs [0:31];
  int          mhalt;

  jedro_1_top #(.BOOT_ADDR(Boot)) dut (
    .clk_i      (clk),
    .rstn_i     (rstn),
    .iram_addr  (iram_addr),
    .iram_rdata (iram_rdata),
    .dram_we    (dram_we),
    .dram_stb   (dram_stb),
    .dram_addr  (dram_addr),
    .dram_wdata (dram_wdata),
    .dram_rdata (32'hDEAD_BEEF),
    .dram_ack   (1'b1),
    .dram_err   (1'b1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Synchronous ROM, word-indexed from Boot; outside the image reads 0 (illegal).
  always @(posedge clk) begin
    logic [31:0] off;
    off = iram_addr - Boot;
    if (off < 32'd256) iram_rdata <= imem[off[7:2]];
    else iram_rdata <= 32'd0;
  end

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", nm, act, exp);
    end
  endtask

  function automatic logic [31:0] enc_i(input logic [2:0] f3, input int rd, input int rs1,
                                        input int imm);
    return {imm[11:0], rs1[4:0], f3, rd[4:0], 7'b0010011};
  endfunction

  function automatic logic [31:0] enc_r(input logic [6:0] f7, input logic [2:0] f3, input int rd,
                                        input int rs1, input int rs2);
    return {f7, rs2[4:0], rs1[4:0], f3, rd[4:0], 7'b0110011};
  endfunction

  function automatic logic [31:0] enc_u(input logic [6:0] op, input int rd, input int imm20);
    return {imm20[19:0], rd[4:0], op};
  endfunction

  // ISA-level reference: run the image word by word until the first illegal one.
  task automatic ref_step(input logic [31:0] w, input logic [31:0] pc, output bit ok);
    logic [6:0]  op, f7;
    logic [2:0]  f3;
    logic [31:0] a, b, y, res, immi, immu;
    bit          is_r, alt;
    op   = w[6:0];
    f3   = w[14:12];
    f7   = w[31:25];
    a    = mregs[w[19:15]];
    b    = mregs[w[24:20]];
    immi = {{20{w[31]}}, w[31:20]};
    immu = {w[31:12], 12'd0};
    ok   = 1'b1;
    res  = 32'd0;
    if (op == 7'b0110111) res = immu;
    else if (op == 7'b0010111) res = pc + immu;
    else if (op == 7'b0010011 || op == 7'b0110011) begin
      is_r = (op == 7'b0110011);
      alt  = (f7 == 7'h20);
      y    = is_r ? b : immi;
      if (is_r) ok = (f7 == 7'h00) || (alt && (f3 == 3'd0 || f3 == 3'd5));
      else if (f3 == 3'd1) ok = (f7 == 7'h00);
      else if (f3 == 3'd5) ok = (f7 == 7'h00) || alt;
      case (f3)
        3'd0: res = (is_r && alt) ? a - y : a + y;
        3'd1: res = a << y[4:0];
        3'd2: res = ($signed(a) < $signed(y)) ? 32'd1 : 32'd0;
        3'd3: res = (a < y) ? 32'd1 : 32'd0;
        3'd4: res = a ^ y;
        3'd5: res = alt ? $signed(a) >>> y[4:0] : a >> y[4:0];
        3'd6: res = a | y;
        default: res = a & y;
      endcase
    end else ok = 1'b0;
    if (ok && w[11:7] != 5'd0) mregs[w[11:7]] = res;
  endtask

  task automatic model_run();
    bit ok;
    for (int i = 0; i < 32; i++) mregs[i] = 32'd0;
    mhalt = 64;
    for (int i = 0; i < 64; i++) begin
      ref_step(imem[i], Boot + 32'(4 * i), ok);
      if (!ok) begin
        mhalt = i;
        break;
      end
    end
  endtask

  function automatic int nonzero_regs();
    int cnt = 0;
    for (int i = 0; i < 32; i++) if (dut.regfile_inst.regfile[i] != 32'd0) cnt++;
    return cnt;
  endfunction

  task automatic do_reset();
    rstn = 1'b0;
    repeat (2) @(negedge clk);
    rstn = 1'b1;
  endtask

  function automatic logic [31:0] rand_instr();
    int k, rd, rs1, rs2, imm;
    logic [2:0] f3;
    logic [6:0] f7;
    k   = $urandom_range(0, 11);
    rd  = $urandom_range(0, 7);
    rs1 = $urandom_range(0, 7);
    rs2 = $urandom_range(0, 7);
    f3  = 3'($urandom_range(0, 7));
    imm = $urandom_range(0, 4095);
    if (k == 0) return enc_u(7'b0110111, rd, $urandom_range(0, 20'hFFFFF));
    if (k == 1) return enc_u(7'b0010111, rd, $urandom_range(0, 20'hFFFFF));
    if (k <= 5) begin
      if (f3 == 3'd1) imm = $urandom_range(0, 31);
      if (f3 == 3'd5) imm = ($urandom_range(0, 1) != 0 ? 32'h400 : 0) | $urandom_range(0, 31);
      return enc_i(f3, rd, rs1, imm);
    end
    f7 = ((f3 == 3'd0 || f3 == 3'd5) && $urandom_range(0, 1) != 0) ? 7'h20 : 7'h00;
    return enc_r(f7, f3, rd, rs1, rs2);
  endfunction

  task automatic compare_all(input string tag);
    for (int i = 0; i < 32; i++)
      check($sformatf("%s x%0d", tag, i), dut.regfile_inst.regfile[i], mregs[i]);
    check({tag, " illegal"}, {31'd0, dut.decoder_inst.illegal_instr_ro}, 32'd1);
    check({tag, " frozen_pc"}, iram_addr, Boot + 32'(4 * (mhalt + 2)));
    check({tag, " dram_idle"}, {27'd0, dram_stb, dram_we} | dram_addr | dram_wdata, 32'd0);
  endtask

  typedef struct {
    string       name;
    logic [31:0] w [6];
    int          ra;
    logic [31:0] va;
    int          rb;
    logic [31:0] vb;
    int          halt;
  } vec_t;

  vec_t vt [11];

  task automatic set_vec(input int i, input string nm, input logic [31:0] w0, input logic [31:0] w1,
                         input logic [31:0] w2, input logic [31:0] w3, input int ra,
                         input logic [31:0] va, input int rb, input logic [31:0] vb,
                         input int halt);
    vt[i].name = nm;
    vt[i].w[0] = w0; vt[i].w[1] = w1; vt[i].w[2] = w2; vt[i].w[3] = w3;
    vt[i].w[4] = 32'd0; vt[i].w[5] = 32'd0;
    vt[i].ra = ra; vt[i].va = va; vt[i].rb = rb; vt[i].vb = vb; vt[i].halt = halt;
  endtask

  initial begin
    rstn = 1'b0;
    for (int i = 0; i < 64; i++) imem[i] = 32'd0;

    // Reset state while held in reset
    repeat (3) @(negedge clk);
    check("reset iram_addr", iram_addr, Boot);
    check("reset regs_nonzero", 32'(nonzero_regs()), 32'd0);
    check("reset illegal", {31'd0, dut.decoder_inst.illegal_instr_ro}, 32'd0);
    check("reset dram", {27'd0, dram_stb, dram_we} | dram_addr | dram_wdata, 32'd0);

    // Directed vectors
    set_vec(0, "sltu_pair", enc_i(0, 3, 0, 1), enc_i(0, 4, 0, 2), enc_r(0, 3, 1, 3, 4),
            enc_r(0, 3, 2, 4, 3), 1, 1, 2, 0, 4);
    set_vec(1, "slt_signed", enc_i(0, 5, 0, -1), enc_r(0, 3, 6, 0, 5), enc_r(0, 2, 7, 0, 5), 0,
            6, 1, 7, 0, 3);
    set_vec(2, "lui_fwd", enc_u(7'b0110111, 8, 20'h12345), enc_i(0, 8, 8, 12'h678), 0, 0,
            8, 32'h1234_5678, 0, 0, 2);
    set_vec(3, "halt_mid", enc_i(0, 9, 0, 5), 0, enc_i(0, 10, 0, 7), 0, 9, 5, 10, 0, 1);
    set_vec(4, "x0_write", enc_i(0, 0, 0, 9), enc_i(0, 1, 0, 9), 0, 0, 0, 0, 1, 9, 2);
    set_vec(5, "sltiu_m1", enc_i(0, 1, 0, 5), enc_i(3, 2, 1, -1), enc_i(2, 3, 1, -1), 0,
            2, 1, 3, 0, 3);
    set_vec(6, "sra_sign", enc_u(7'b0110111, 1, 20'h80000), enc_i(5, 2, 1, 12'h404),
            enc_i(0, 3, 0, 36), enc_r(7'h20, 5, 4, 1, 3), 2, 32'hF800_0000, 4, 32'hF800_0000, 4);
    set_vec(7, "sub_wrap", enc_i(0, 1, 0, 1), enc_r(7'h20, 0, 2, 0, 1), enc_r(0, 0, 3, 2, 1), 0,
            2, 32'hFFFF_FFFF, 3, 0, 3);
    set_vec(8, "auipc_lowbits", enc_i(0, 0, 0, 0), enc_u(7'b0010111, 1, 1),
            enc_i(0, 2, 0, 3) ^ 32'h2, enc_i(0, 3, 0, 1), 1, Boot + 32'h1004, 3, 0, 2);
    set_vec(9, "bad_funct7", enc_i(0, 1, 0, 3), enc_r(7'h20, 1, 2, 1, 1), enc_i(0, 3, 0, 1), 0,
            1, 3, 3, 0, 1);
    set_vec(10, "shamt_low5", enc_i(0, 1, 0, 3), enc_i(0, 2, 0, 33), enc_r(0, 1, 3, 1, 2),
            enc_r(0, 5, 4, 3, 2), 3, 6, 4, 3, 4);

    for (int v = 0; v < 11; v++) begin
      for (int i = 0; i < 64; i++) imem[i] = 32'd0;
      for (int i = 0; i < 6; i++) imem[i] = vt[v].w[i];
      do_reset();
      repeat (20) @(negedge clk);
      check($sformatf("%s x%0d", vt[v].name, vt[v].ra),
            dut.regfile_inst.regfile[vt[v].ra], vt[v].va);
      check($sformatf("%s x%0d", vt[v].name, vt[v].rb),
            dut.regfile_inst.regfile[vt[v].rb], vt[v].vb);
      check({vt[v].name, " illegal"}, {31'd0, dut.decoder_inst.illegal_instr_ro}, 32'd1);
      check({vt[v].name, " frozen_pc"}, iram_addr, Boot + 32'(4 * (vt[v].halt + 2)));
    end

    // Writeback latency and back-to-back forwarding
    for (int i = 0; i < 64; i++) imem[i] = 32'd0;
    imem[0] = enc_i(0, 1, 0, 1);
    imem[1] = enc_i(0, 2, 1, 1);
    do_reset();
    @(negedge clk);
    check("lat edge1 x1", dut.regfile_inst.regfile[1], 32'd0);
    @(negedge clk);
    check("lat edge2 x1", dut.regfile_inst.regfile[1], 32'd0);
    repeat (2) @(negedge clk);
    check("lat edge4 x1", dut.regfile_inst.regfile[1], 32'd1);
    @(negedge clk);
    check("lat edge5 x2", dut.regfile_inst.regfile[2], 32'd2);

    // Randomized programs against the reference model
    for (int p = 0; p < 8; p++) begin
      for (int i = 0; i < 64; i++) imem[i] = 32'd0;
      for (int i = 0; i < 30; i++) imem[i] = rand_instr();
      if (p % 2 == 1) imem[$urandom_range(5, 29)] = 32'd0;
      model_run();
      do_reset();
      repeat (60) @(negedge clk);
      compare_all($sformatf("rand%0d", p));
    end

    // Reset pulsed mid-program, then identical re-execution
    for (int i = 0; i < 64; i++) imem[i] = 32'd0;
    for (int i = 0; i < 30; i++) imem[i] = rand_instr();
    imem[0] = enc_i(0, 1, 0, 77);
    model_run();
    do_reset();
    repeat (12) @(negedge clk);
    #2 rstn = 1'b0;
    #1;
    check("midrst iram_addr", iram_addr, Boot);
    check("midrst regs_nonzero", 32'(nonzero_regs()), 32'd0);
    check("midrst illegal", {31'd0, dut.decoder_inst.illegal_instr_ro}, 32'd0);
    @(negedge clk);
    rstn = 1'b1;
    repeat (60) @(negedge clk);
    compare_all("rerun");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
